// File: rtl/gemm_accum_if.sv
// Streaming bus between the MAC column and the accumulator.
// Carries the partial-sum input stream and the result output handshake.
// The slave modport is the accumulator; the master modport is whoever feeds
// partial sums and consumes results.
interface gemm_accum_if #(
  parameter int C_DATA_WIDTH = 32
);
  logic [C_DATA_WIDTH-1:0] in_data;
  logic                    in_valid;
  logic [C_DATA_WIDTH-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;

  modport slave (
    input  in_data,
    input  in_valid,
    input  out_ready,
    output out_data,
    output out_valid
  );

  modport master (
    output in_data,
    output in_valid,
    output out_ready,
    input  out_data,
    input  out_valid
  );
endinterface

// File: rtl/gemm_accum.sv
// GEMM column accumulator.
// Sums cfg_passes partial sums from the bottom of a MAC column into one
// result and queues each result in a small FIFO for downstream.
// Optional macro GEMM_ACCUM_SAT_EN: accumulate adds saturate (signed)
// instead of wrapping.
module gemm_accum #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_FIFO_DEPTH = 4
) (
  input  logic                              clock,
  input  logic                              resetn,
  input  logic [7:0]                        cfg_passes,
  output logic [$clog2(C_FIFO_DEPTH):0]     fifo_count,
  output logic                              overflow,
  gemm_accum_if.slave                       bus
);

  localparam int W  = C_DATA_WIDTH;
  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [0:0] {S_IDLE, S_ACC} state_t;

  // Accumulate add: wraps by default, clamps on signed overflow when enabled.
  function automatic logic signed [W-1:0] acc_add(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
    logic signed [W-1:0] s;
    s = a + b;
`ifdef GEMM_ACCUM_SAT_EN
    if ((a[W-1] == b[W-1]) && (s[W-1] != a[W-1])) begin
      s = a[W-1] ? SAT_MIN : SAT_MAX;
    end
`endif
    return s;
  endfunction

  state_t              state_q, state_d;
  logic signed [W-1:0] acc_q, acc_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          tgt_q, tgt_d;

  logic [7:0]          passes_eff;
  logic                last_beat;
  logic signed [W-1:0] in_s;
  logic signed [W-1:0] sum;
  logic                push;
  logic [W-1:0]        push_data;

  logic [W-1:0]        mem [C_FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q;
  logic                overflow_q;
  logic                full;
  logic                pop;
  logic                push_ok;

  assign passes_eff = (cfg_passes == 8'd0) ? 8'd1 : cfg_passes;
  assign in_s       = $signed(bus.in_data);
  assign sum        = acc_add(acc_q, in_s);
  assign last_beat  = (8'(cnt_q + 8'd1) == tgt_q);

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a target of one never leaves idle; otherwise run until the last beat.
  always_comb begin
    state_d = state_q;
    if (bus.in_valid) begin
      case (state_q)
        S_IDLE:  state_d = (passes_eff == 8'd1) ? S_IDLE : S_ACC;
        S_ACC:   state_d = last_beat ? S_IDLE : S_ACC;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs: accumulator/count/target next values and the FIFO push request.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    tgt_d     = tgt_q;
    push      = 1'b0;
    push_data = '0;
    if (bus.in_valid) begin
      case (state_q)
        S_IDLE: begin
          tgt_d = passes_eff;
          acc_d = in_s;
          if (passes_eff == 8'd1) begin
            push      = 1'b1;
            push_data = bus.in_data;
            cnt_d     = 8'd0;
          end else begin
            cnt_d = 8'd1;
          end
        end
        S_ACC: begin
          acc_d = sum;
          if (last_beat) begin
            push      = 1'b1;
            push_data = sum;
            cnt_d     = 8'd0;
          end else begin
            cnt_d = 8'(cnt_q + 8'd1);
          end
        end
        default: begin
          cnt_d = 8'd0;
        end
      endcase
    end
  end

  // Accumulator, beat count and latched pass target.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc_q <= '0;
      cnt_q <= 8'd0;
      tgt_q <= 8'd1;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      tgt_q <= tgt_d;
    end
  end

  // ---- result FIFO stage ----
  assign full    = (count_q == CW'(C_FIFO_DEPTH));
  assign pop     = bus.out_valid && bus.out_ready;
  assign push_ok = push && (!full || pop);

  // FIFO pointers, occupancy and sticky drop flag.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  // FIFO storage; emptiness is tracked by count, so no reset is needed here.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = bus.out_valid ? mem[rd_ptr_q] : '0;
  assign fifo_count    = count_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_gemm_accum.sv
module tb_gemm_accum;

  logic       clock = 1'b0;
  logic       resetn;
  logic [7:0] cfg_passes;
  logic [2:0] fifo_count;
  logic       overflow;
  int         tests = 0;
  int         fails = 0;
  logic [31:0] sat_exp_pos, sat_exp_neg;

  gemm_accum_if #(.C_DATA_WIDTH(32)) bus ();

  gemm_accum #(.C_DATA_WIDTH(32), .C_FIFO_DEPTH(4)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .cfg_passes (cfg_passes),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef GEMM_ACCUM_SAT_EN
    sat_exp_pos = 32'h7FFF_FFFF;
    sat_exp_neg = 32'h8000_0000;
`else
    sat_exp_pos = 32'h8000_0000;
    sat_exp_neg = 32'h7FFF_FFFF;
`endif
    resetn        = 1'b0;
    cfg_passes    = 8'd0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_count",     fifo_count,    3'd0);
    check("rst_overflow",  overflow,      1'b0);
    check("rst_out_data",  bus.out_data,  32'd0);
    resetn = 1'b1;
    tick();

    // Three-pass sum 5 + 7 - 2
    cfg_passes = 8'd3;
    bus.in_valid = 1'b1;
    bus.in_data = 32'd5;         tick();
    bus.in_data = 32'd7;         tick();
    check("p3_not_early", bus.out_valid, 1'b0);
    bus.in_data = 32'hFFFF_FFFE; tick();
    bus.in_valid = 1'b0;
    check("p3_valid", bus.out_valid, 1'b1);
    check("p3_data",  bus.out_data,  32'd10);
    check("p3_count", fifo_count,    3'd1);
    bus.out_ready = 1'b1; tick();
    bus.out_ready = 1'b0;
    check("p3_drained", fifo_count, 3'd0);

    // Passes 0 acts as 1: four single-beat results fill the FIFO
    cfg_passes = 8'd0;
    bus.in_valid = 1'b1;
    bus.in_data = 32'd1; tick();
    bus.in_data = 32'd2; tick();
    bus.in_data = 32'd3; tick();
    bus.in_data = 32'd4; tick();
    bus.in_valid = 1'b0;
    check("single_count", fifo_count,   3'd4);
    check("single_ovf",   overflow,     1'b0);
    check("single_head",  bus.out_data, 32'd1);

    // Full, no pop: drop and flag
    bus.in_valid = 1'b1; bus.in_data = 32'd9; tick();
    bus.in_valid = 1'b0;
    check("full_drop_ovf",   overflow,     1'b1);
    check("full_drop_count", fifo_count,   3'd4);
    check("full_drop_head",  bus.out_data, 32'd1);

    // Full with simultaneous pop: accepted
    bus.in_valid = 1'b1; bus.in_data = 32'd10; bus.out_ready = 1'b1; tick();
    bus.in_valid = 1'b0;
    check("full_pp_count", fifo_count,   3'd4);
    check("full_pp_ovf",   overflow,     1'b1);
    check("full_pp_head",  bus.out_data, 32'd2);
    tick(); check("drain_3",  bus.out_data, 32'd3);
    tick(); check("drain_4",  bus.out_data, 32'd4);
    tick(); check("drain_10", bus.out_data, 32'd10);
    tick();
    bus.out_ready = 1'b0;
    check("drain_empty", fifo_count,   3'd0);
    check("drain_data0", bus.out_data, 32'd0);

    // Asynchronous reset clears sticky overflow immediately
    resetn = 1'b0; #1;
    check("async_rst_ovf", overflow, 1'b0);
    tick();
    resetn = 1'b1;
    tick();

    // Overflow behaviour of the accumulate add
    cfg_passes = 8'd2;
    bus.in_valid = 1'b1;
    bus.in_data = 32'h7FFF_FFFF; tick();
    bus.in_data = 32'h0000_0001; tick();
    bus.in_data = 32'h8000_0000; tick();
    bus.in_data = 32'hFFFF_FFFF; tick();
    bus.in_valid = 1'b0;
    check("sat_count", fifo_count,   3'd2);
    check("sat_pos",   bus.out_data, {32'd0, sat_exp_pos});
    bus.out_ready = 1'b1; tick();
    check("sat_neg",   bus.out_data, {32'd0, sat_exp_neg});
    tick();
    bus.out_ready = 1'b0;

    // Reset mid-result discards the partial sum
    cfg_passes = 8'd4;
    bus.in_valid = 1'b1;
    bus.in_data = 32'd1; tick();
    bus.in_data = 32'd1; tick();
    bus.in_valid = 1'b0;
    resetn = 1'b0; tick();
    resetn = 1'b1; tick();
    cfg_passes = 8'd2;
    bus.in_valid = 1'b1;
    bus.in_data = 32'd3; tick();
    check("abort_none", bus.out_valid, 1'b0);
    bus.in_data = 32'd4; tick();
    bus.in_valid = 1'b0;
    check("abort_count", fifo_count,   3'd1);
    check("abort_data",  bus.out_data, 32'd7);
    bus.out_ready = 1'b1; tick();
    bus.out_ready = 1'b0;

    // Gaps between beats; cfg change mid-result ignored
    cfg_passes = 8'd2;
    bus.in_valid = 1'b1; bus.in_data = 32'd6; tick();
    bus.in_valid = 1'b0; cfg_passes = 8'd5;
    tick(); tick(); tick();
    check("gap_none", bus.out_valid, 1'b0);
    bus.in_valid = 1'b1; bus.in_data = 32'd8; tick();
    bus.in_valid = 1'b0;
    check("gap_valid", bus.out_valid, 1'b1);
    check("gap_data",  bus.out_data,  32'd14);
    check("gap_count", fifo_count,    3'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gemm_accum.md
GEMM_ACCUM -- requirements
Module: gemm_accum

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 32, data width of input and output results.
REQ-002 SHALL have parameter C_FIFO_DEPTH, default 4, result FIFO depth in entries, power of two, >= 2.
REQ-003 SHALL have port clock, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port resetn, input, 1, reset, asynchronous assertion, active-low.
REQ-005 SHALL have port in_data, input, C_DATA_WIDTH, partial sum from the Cout of the last MAC in a column.
REQ-006 SHALL have port in_valid, input, 1, in_data is valid this cycle; no backpressure exists upstream.
REQ-007 SHALL have port cfg_passes, input, 8, number of in_valid beats summed per result; 0 is treated as 1.
REQ-008 SHALL have port out_data, output, C_DATA_WIDTH, head-of-FIFO result.
REQ-009 SHALL have port out_valid, output, 1, FIFO not empty.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts out_data when out_valid and out_ready are both high.
REQ-011 SHALL have port fifo_count, output, $clog2(C_FIFO_DEPTH)+1, entries currently held.
REQ-012 SHALL have port overflow, output, 1, sticky: a completed result was dropped.

Function
REQ-013 SHALL implement FSM states S_IDLE (no beats summed) and S_ACC (result in progress).
REQ-014 In S_IDLE, on in_valid, SHALL latch cfg_passes (0 mapped to 1) as pass target, load acc <= in_data, and set beat count to 1.
REQ-015 In S_IDLE, if latched target == 1, SHALL push in_data directly as a result and remain in S_IDLE; otherwise SHALL go to S_ACC.
REQ-016 In S_ACC, on in_valid, SHALL update acc <= acc + in_data and increment beat count.
REQ-017 When the beat brings the count to the target, SHALL push acc + in_data to the FIFO, clear the count, and return to S_IDLE.
REQ-018 cfg_passes changes SHALL take effect only at the next S_IDLE beat; an in-progress result uses its latched target.
REQ-019 Cycles without in_valid SHALL leave acc, count and state unchanged (gaps allowed).
REQ-020 Result latency SHALL be exactly 1 cycle: out_valid rises on the clock edge after the final beat if the FIFO was empty.
REQ-021 FIFO SHALL be first-in first-out; out_data SHALL be stable while out_valid is high and out_ready is low.
REQ-022 Simultaneous push and pop SHALL both succeed at any fill level, including full, leaving fifo_count unchanged.
REQ-023 A push while full without a simultaneous pop SHALL discard the new result, leave the FIFO unchanged, and set overflow.
REQ-024 Read and write pointers SHALL wrap modulo C_FIFO_DEPTH; fifo_count SHALL distinguish full from empty.
REQ-025 Without saturation, addition SHALL be two's-complement modulo 2^C_DATA_WIDTH.

Reset
REQ-026 resetn low SHALL immediately force S_IDLE, acc=0, count=0, FIFO empty, out_valid=0, fifo_count=0, overflow=0, out_data=0.
REQ-027 Reset mid-result SHALL discard the partial sum; the first in_valid after release SHALL start a new result.
REQ-028 Reset release SHALL be synchronous to clock; no state update SHALL occur on the releasing edge.

Configuration
REQ-029 Macro GEMM_ACCUM_SAT_EN defined SHALL make every accumulate add signed-saturating: clamp to 2^(W-1)-1 on positive overflow and -2^(W-1) on negative overflow.
REQ-030 Macro GEMM_ACCUM_SAT_EN undefined SHALL use wrapping addition per REQ-025; there SHALL be no other behavioural difference.

Verification
REQ-031 Setup cfg_passes=3, in_data 5,7,-2 on consecutive cycles -> one cycle later out_valid=1, out_data=10, fifo_count=1.
REQ-032 Setup cfg_passes=0, four single beats 1,2,3,4 with out_ready=0 -> four results 1,2,3,4 queued in order, fifo_count=4, overflow=0.
REQ-033 Setup FIFO full (depth 4), out_ready=0, one more result completes -> result dropped, overflow=1, fifo_count=4; same event with out_ready=1 -> accepted, count stays 4, overflow unchanged.
REQ-034 Setup W=32, cfg_passes=2, beats 0x7FFFFFFF then 1 -> with GEMM_ACCUM_SAT_EN 0x7FFFFFFF, without it 0x80000000.
REQ-035 Setup cfg_passes=4, two beats, resetn pulsed low, then cfg_passes=2 and beats 3,4 -> single result 7; no result from the aborted partial sum.
REQ-036 Setup cfg_passes=2, beats separated by 3 idle cycles, cfg_passes changed to 5 after the first beat -> result is the sum of 2 beats, emitted 1 cycle after the second beat.
